instr_assembler: RTL

//   Inverse of the instruction field splitter: packs MIPS fields (opcode/rs/rt/rd/shamt/func/imm/instr_index)

---
 rtl/instr_assembler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_assembler.sv
// -----------------------------------------------------------------------------
// instr_assembler
//   Packs MIPS instruction fields into 32-bit R/I/J words. Each word is queued
//   in a small FIFO and then streamed to the instruction-memory write port,
//   together with its byte address. The address counter starts at BASE_ADDR
//   and advances by 4 for every word that leaves the FIFO.
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   flush                 synchronous clear of the FIFO, address counter and err
//   in_valid / in_ready   field-bundle handshake (in_ready = FIFO not full)
//   in_fmt                00 R, 01 I, 10 J, 11 illegal (accepted and dropped)
//   in_opcode .. in_index instruction fields (unused fields are ignored)
//   out_valid / out_ready handshake for the word at the head of the FIFO
//   out_instr, out_addr   head word (0 when empty) and its byte address
//   count                 FIFO occupancy
//   err                   one-cycle pulse after an illegal bundle is accepted
// -----------------------------------------------------------------------------
module instr_assembler #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_fmt,
  input  logic [5:0]               in_opcode,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_shamt,
  input  logic [5:0]               in_func,
  input  logic [15:0]              in_imm,
  input  logic [25:0]              in_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_ILL = 2'b11;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic          err_q, err_d;

  logic [31:0]   word_d;
  logic          accept;
  logic          push;
  logic          pop;

  // Field packing; fields that do not belong to the format are ignored.
  always_comb begin
    word_d = {in_opcode, in_index};
    case (in_fmt)
      FMT_R:   word_d = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_func};
      FMT_I:   word_d = {in_opcode, in_rs, in_rt, in_imm};
      default: word_d = {in_opcode, in_index};
    endcase
  end

  // in_ready depends on occupancy only, so a full FIFO refuses a bundle even
  // in the cycle it is being popped.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign out_addr  = addr_q;
  assign count     = count_q;
  assign err       = err_q;

  // flush wins over any handshake on the same edge.
  assign accept = in_valid && in_ready && !flush;
  assign push   = accept && (in_fmt != FMT_ILL);
  assign pop    = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    err_d    = accept && (in_fmt == FMT_ILL);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = BASE_ADDR;
      err_d    = 1'b0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        addr_d   = addr_q + 32'd4;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset: an entry is only visible while count covers it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word_d;
  end

endmodule
